// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier family.
// Holds the controller state encoding and the operand magnitude helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAG_W         = 32;

    // Caller must pass the operand sign-extended to MAG_W bits whenever is_signed is set.
    function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] value,
                                                 input logic             is_signed);
        if (is_signed && value[MAG_W-1]) begin
            return ~value + MAG_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/seq_mult_hs.sv
// Radix-2 shift-add multiplier with valid/ready on both sides, signed or unsigned per operation.
// One operation in flight; the product is held in DONE until the sink takes it.
module seq_mult_hs
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [MAG_W-1:0]   aExt, bExt, aMag, bMag;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] finalVal;
    logic               accept;
    logic               unusedBits;

    // Operand magnitudes; signed operands are widened with their sign first.
    always_comb begin
        if (in_signed) begin
            aExt = MAG_W'($signed(A));
            bExt = MAG_W'($signed(B));
        end else begin
            aExt = MAG_W'(A);
            bExt = MAG_W'(B);
        end
        aMag = abs_mag(aExt, in_signed);
        bMag = abs_mag(bExt, in_signed);
    end

    // work_q holds {accumulator, remaining multiplier bits}; partial carries the add-out bit.
    always_comb begin
        partial  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mcand_q} : '0);
        shifted  = {partial, work_q[WIDTH-1:0]} >> 1;
        finalVal = neg_q ? -shifted[2*WIDTH-1:0] : shifted[2*WIDTH-1:0];
    end

    assign unusedBits = ^{aMag, bMag, shifted[2*WIDTH]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        work_d    = work_q;
        neg_d     = neg_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                busy   = 1'b1;
                work_d = shifted[2*WIDTH-1:0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = finalVal;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared by IDLE and DONE, so a consume and a new accept can share one edge.
        accept = in_ready && in_valid;
        if (accept) begin
            mcand_d = aMag[WIDTH-1:0];
            work_d  = {{WIDTH{1'b0}}, bMag[WIDTH-1:0]};
            neg_d   = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt_d   = CNT_W'(WIDTH);
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            work_q  <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            work_q  <= work_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised successor to the team's fixed 8x8 iterative multiplier.
- Radix-2 shift-add multiplier: operand width set by parameter, signed/unsigned mode chosen per operation.
- valid/ready handshakes on input and output, so a result is held until consumed.
- Sits between a register-mapped operand source and a result sink in the arithmetic datapath; one operation in flight at a time.

Parameters:
- WIDTH, 8: operand width in bits, legal range 2..32; product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets; release is synchronous to clk upstream).
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands this cycle.
- in_signed  in  1  1 = treat A and B as two's complement; 0 = unsigned. Sampled with A/B.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- out_valid  out  1  prod holds a completed result.
- out_ready  in  1  sink accepts result this cycle.
- prod  out  2*WIDTH  product; stable while out_valid=1.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prod=0, out_valid=0, busy=0, counter=0, internal operand/accumulator registers=0. in_ready=1 once reset is released.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, capture operands and go to RUN.
  - RUN: in_ready=0, busy=1.
  - DONE: out_valid=1.
- Capture (IDLE to RUN):
  - Latch |A| and |B| as WIDTH-bit unsigned magnitudes, plus neg = in_signed & (A[MSB]^B[MSB]).
  - Unsigned mode takes magnitudes as-is.
  - Most-negative value (e.g. -128 at WIDTH=8) has magnitude 2^(WIDTH-1), which fits unsigned; no special case.
  - Load counter=WIDTH and clear the accumulator.
- RUN, one iteration per cycle:
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator.
  - Shift the {carry, acc, multiplier} register right by 1; decrement the counter.
  - The iteration where counter goes 1 to 0 also applies conditional two's-complement negation (when neg=1) and writes prod.
  - Then go to DONE.
- Latency: if operands are accepted at edge t, out_valid=1 after edge t+WIDTH (WIDTH cycles; 8 at default).
- DONE:
  - prod and out_valid are held until an edge with out_ready=1.
  - in_ready = out_ready in DONE, so a new operation can be accepted on the same edge the result is consumed.
  - Simultaneous accept and consume: go directly to RUN; out_valid drops; prod keeps its old value until the next completion.
  - out_ready=1 with in_valid=0: go to IDLE, out_valid=0, prod retains its last value.
- in_valid during RUN is ignored (in_ready=0); A/B changes have no effect after capture.
- Asynchronous reset mid-RUN or mid-DONE: operation abandoned, every register returns to its reset value immediately; no spurious out_valid after release.
- Width rules:
  - Unsigned result range is 0..(2^WIDTH-1)^2.
  - Signed result range is -(2^(2W-2)-2^(W-1))..2^(2W-2).
  - Both fit 2*WIDTH bits; no overflow flag.
- Zero operand: still takes WIDTH cycles; no early termination, so latency is deterministic.

Decomposition:
- Package mult_pkg holds:
  - typedef state_t {IDLE, RUN, DONE};
  - localparam for default WIDTH;
  - a function abs_mag(value, is_signed) returning the WIDTH-bit magnitude.
- No sub-module required. One optional sub-module, mult_sign_fix (conditional 2*WIDTH two's-complement negate), is acceptable if it is reused elsewhere.

Test Plan:
- Unsigned 255x255, 0x255, 1x255, out_ready=1: prod=65025, 0, 255; each out_valid exactly 8 cycles after the accept edge.
- Signed -128x-128, -128x127, -1x1, 127x-3: prod=16384, 0xC080 (-16256), 0xFFFF (-1), 0xFE83 (-381).
- Backpressure: 37x83 unsigned with out_ready=0 for 20 cycles. Require out_valid=1 and prod=3071 stable throughout, in_ready=0; after out_ready=1 for one edge, out_valid=0.
- Back-to-back: hold in_valid=1 with 5x6, 7x8, 9x10 and out_ready=1. Require each new accept on the same edge as the previous consume; prod=30, 56, 90; 3 results in 3*(8+1) cycles.
- Reset mid-RUN: accept 200x3, assert reset=0 at cycle 4 for 2 cycles. Require prod=0 and out_valid=0 immediately; after release, 15x17 gives 255 with normal latency.
- WIDTH=16 instance: 65535x65535 unsigned gives 0xFFFE0001 after 16 cycles; signed -32768x-32768 gives 0x40000000.
